// File: rtl/seg_disp_arbiter_if.sv
// Bundle between the debug taps (requesters) and the display arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface seg_disp_arbiter_if;
  logic [3:0]  Req;
  logic [15:0] Data0;
  logic [15:0] Data1;
  logic [15:0] Data2;
  logic [15:0] Data3;
  logic [3:0]  Grant;
  logic [1:0]  Owner;
  logic [15:0] Disp_Data;
  logic        Valid;
  logic        Scan_Tick;

  modport master (
    output Req, Data0, Data1, Data2, Data3,
    input  Grant, Owner, Disp_Data, Valid, Scan_Tick
  );

  modport slave (
    input  Req, Data0, Data1, Data2, Data3,
    output Grant, Owner, Disp_Data, Valid, Scan_Tick
  );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display with a minimum dwell
// measured in scan ticks; also generates the scan tick for the digit driver.
module seg_disp_arbiter #(
  parameter int SCAN_DIV = 50000,
  parameter int DWELL    = 2000
) (
  input logic               CLK,
  input logic               RST,
  seg_disp_arbiter_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_PRE   = SCAN_W'(SCAN_DIV - 2);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  state_t             state_reg;
  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic               scan_tick_reg;
  logic [DWELL_W-1:0] dwell_cnt_reg;
  logic [1:0]         ptr_reg;
  logic [1:0]         owner_reg;
  logic [3:0]         grant_reg;
  logic               valid_reg;
  logic [15:0]        disp_reg;

  logic [15:0] data_arr [4];
  logic [3:0]  others;
  logic [1:0]  idle_pick;
  logic [1:0]  exp_pick;
  logic        req_owner;
  logic        expiry;

  // First requester at or after start, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign data_arr[0] = bus.Data0;
  assign data_arr[1] = bus.Data1;
  assign data_arr[2] = bus.Data2;
  assign data_arr[3] = bus.Data3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_others
      assign others[gi] = bus.Req[gi] && (owner_reg != 2'(gi));
    end
  endgenerate

  assign req_owner = bus.Req[owner_reg];
  assign idle_pick = rr_pick(bus.Req, ptr_reg);
  assign exp_pick  = rr_pick(others, ptr_reg);
  // scan_tick_reg is high exactly while the edge about to happen is a tick edge.
  assign expiry    = scan_tick_reg && (dwell_cnt_reg == DWELL_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      scan_cnt_reg  <= '0;
      scan_tick_reg <= 1'b0;
      dwell_cnt_reg <= '0;
      ptr_reg       <= 2'd0;
      owner_reg     <= 2'd0;
      grant_reg     <= 4'b0000;
      valid_reg     <= 1'b0;
      disp_reg      <= 16'h0000;
    end else begin
      if (scan_cnt_reg == SCAN_LAST) begin
        scan_cnt_reg <= '0;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
      scan_tick_reg <= (scan_cnt_reg == SCAN_PRE);

      case (state_reg)
        IDLE: begin
          dwell_cnt_reg <= '0;
          if (|bus.Req) begin
            owner_reg <= idle_pick;
            grant_reg <= 4'b0001 << idle_pick;
            valid_reg <= 1'b1;
            ptr_reg   <= idle_pick + 2'd1;
            state_reg <= SHOW;
          end
        end
        SHOW, HOLD: begin
          if (expiry) begin
            if (state_reg == SHOW) disp_reg <= data_arr[owner_reg];
            dwell_cnt_reg <= '0;
            if (|others) begin
              owner_reg <= exp_pick;
              grant_reg <= 4'b0001 << exp_pick;
              ptr_reg   <= exp_pick + 2'd1;
              state_reg <= SHOW;
            end else if (req_owner) begin
              ptr_reg   <= owner_reg + 2'd1;
              state_reg <= SHOW;
            end else begin
              grant_reg <= 4'b0000;
              valid_reg <= 1'b0;
              state_reg <= IDLE;
            end
          end else begin
            if (scan_tick_reg) dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
            // A falling request freezes the display instead of loading new data.
            if (state_reg == SHOW) begin
              if (req_owner) begin
                disp_reg <= data_arr[owner_reg];
              end else begin
                state_reg <= HOLD;
              end
            end else if (req_owner) begin
              state_reg <= SHOW;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= 4'b0000;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Grant     = grant_reg;
  assign bus.Owner     = owner_reg;
  assign bus.Disp_Data = disp_reg;
  assign bus.Valid     = valid_reg;
  assign bus.Scan_Tick = scan_tick_reg;

endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
- Shares the 4-digit seven-segment display between up to four requesters, e.g. PC, ALU result, memory data and a debug register.
- Grants the display round-robin with a guaranteed minimum dwell per owner, so every value stays on the display long enough to read.
- Outputs the selected 16-bit value and a scan-tick pulse to the digit-scanning display driver, which steps one digit per tick.
- Sits between the datapath debug taps and the display driver.

Parameters:
- SCAN_DIV, 50000, CLK cycles per Scan_Tick pulse (>=2).
- DWELL, 2000, minimum number of Scan_Tick pulses an owner keeps the display (>=1).

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  synchronous reset, active-high; sampled on the CLK rising edge.
- Req  input  4  request per source; Req[i] is level-sensitive.
- Data0..Data3  input  16 each  value source i wants displayed.
- Grant  output  4  one-hot current owner; 4'b0000 when idle.
- Owner  output  2  binary index of the current owner.
- Disp_Data  output  16  value to the display driver.
- Valid  output  1  high while an owner holds the display.
- Scan_Tick  output  1  one-cycle pulse every SCAN_DIV cycles.

Behaviour:

Reset (RST=1 at a rising edge, takes effect that edge, including mid-dwell):
- Grant=0, Owner=0, Disp_Data=16'h0000, Valid=0, Scan_Tick=0.
- Scan counter=0, dwell counter=0, RR pointer=0, state=IDLE.

Scan divider:
- Free-running counter 0..SCAN_DIV-1, independent of arbitration state.
- Scan_Tick=1 exactly in the cycle the counter equals SCAN_DIV-1, then the counter wraps to 0.
- First pulse occurs SCAN_DIV cycles after reset deassertion.

RR pointer:
- Search order is ptr, ptr+1, ... mod 4.
- After each grant, ptr becomes winner+1 mod 4.

FSM states:
- IDLE:
  - Valid=0, Grant=0, Disp_Data holds its last value.
  - If Req!=0, pick the winner by RR search → SHOW.
  - The Grant/Owner/Valid registers update at the same edge that samples Req (1-cycle latency from Req to Grant).
  - Dwell counter cleared.
- SHOW:
  - Disp_Data <= Data[Owner] every cycle (registered, 1-cycle latency, tracks live data).
  - Dwell counter increments on each Scan_Tick.
  - If Req[Owner] falls before dwell expiry → HOLD.
- HOLD:
  - Owner keeps Grant and Valid; Disp_Data frozen at its last value.
  - Dwell continues counting.
  - A Req[Owner] reassertion during HOLD returns to SHOW without resetting dwell.
- Dwell expiry (Scan_Tick while dwell counter==DWELL-1, in SHOW or HOLD), resolved at that edge:
  - Another Req[j] set (j!=Owner): RR-select among the others → SHOW with the new owner, dwell cleared.
  - Only Req[Owner] set: stay in SHOW, dwell cleared (re-grant).
  - No Req: → IDLE.
- Simultaneous arrival of several requests in IDLE is resolved purely by RR order from ptr.
- A new request arriving mid-dwell never preempts the owner.
- Req changes in the expiry cycle itself are honoured; that cycle's Req is the value sampled.
- Counter widths are sized from the parameters; no overflow is possible because the counters are compared and cleared at the bound.

Test Plan (SCAN_DIV=4, DWELL=3, so one dwell is 12 cycles):
1. Reset, then check tick timing → all outputs 0 during reset; Scan_Tick pulses on cycles 4, 8, 12… after reset release, width 1.
2. Single request: Req=4'b0100 with Data2=16'h1234 → next cycle Grant=4'b0100, Owner=2, Valid=1; Disp_Data=16'h1234 one cycle later and follows Data2 changes.
3. Contention: Req=4'b1011 held from IDLE (ptr=0) → owners 0, 1, 3, 0… with each grant lasting exactly 3 ticks; no preemption when Req[2] rises mid-dwell, and source 2 is granted at the next expiry where it is next in RR order.
4. Owner drops early: owner 1 drops Req after 1 tick while Data1 changes to 16'hBEEF → Disp_Data frozen at the old value, Grant=4'b0010 held until the 3rd tick, then IDLE with Valid=0 and Grant=0.
5. Sole requester stays: Req=4'b0001 held continuously → Grant stays 4'b0001 across expiries and the dwell counter restarts every 3 ticks.
6. Reset mid-dwell: assert RST during SHOW → at the next edge Grant=0, Valid=0, Disp_Data=0; after release with Req=4'b1000, grant goes to source 3 (ptr restarted at 0, and 0–2 are not requesting).
